// File: rtl/mul_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_unit_pkg
//
// Purpose: shared encodings for the EX-stage multiply unit. Holds the 2-bit
// mulctl op-select codes driven by the EX-stage controller, the multiply FSM
// state encoding, and helpers that say which operands are signed for each op.
//
// Contents:
//   MULCTL_MUL / MULCTL_MULH / MULCTL_MULHSU / MULCTL_MULHU  op-select codes
//   mul_state_e                                              FSM state encoding
//   rs1_is_signed(op), rs2_is_signed(op)                     operand signedness
// -----------------------------------------------------------------------------
package mul_unit_pkg;

    // Op-select codes on mulctl, as issued by the EX-stage controller.
    localparam logic [1:0] MULCTL_MUL    = 2'b00;
    localparam logic [1:0] MULCTL_MULH   = 2'b01;
    localparam logic [1:0] MULCTL_MULHSU = 2'b10;
    localparam logic [1:0] MULCTL_MULHU  = 2'b11;

    // Multiply FSM state encoding.
    localparam logic [1:0] STATE_IDLE = 2'b00;
    localparam logic [1:0] STATE_RUN  = 2'b01;
    localparam logic [1:0] STATE_DONE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_RUN  = STATE_RUN,
        ST_DONE = STATE_DONE
    } mul_state_e;

    // rs1 is treated as signed for mulh and mulhsu.
    function automatic logic rs1_is_signed(input logic [1:0] op);
        return (op == MULCTL_MULH) || (op == MULCTL_MULHSU);
    endfunction

    // rs2 is treated as signed for mulh only.
    function automatic logic rs2_is_signed(input logic [1:0] op);
        return (op == MULCTL_MULH);
    endfunction

endpackage

// File: rtl/mul_step.sv
// -----------------------------------------------------------------------------
// mul_step
//
// Purpose: one shift-add step of the iterative multiplier. Adds the already
// aligned multiplicand, shifted by a further i places, for every set bit i of
// the BITS_PER_CYCLE multiplier bits retired this cycle.
//
// Ports:
//   acc          in   2*XLEN        running partial product
//   mcand        in   2*XLEN        multiplicand aligned to the current position
//   mplier_bits  in   BITS_PER_CYCLE multiplier bits for this step, LSB first
//   acc_next     out  2*XLEN        partial product after this step
// -----------------------------------------------------------------------------
module mul_step
    import mul_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*XLEN-1:0]         acc,
    input  logic [2*XLEN-1:0]         mcand,
    input  logic [BITS_PER_CYCLE-1:0] mplier_bits,
    output logic [2*XLEN-1:0]         acc_next
);

    // Conditional-add chain: one adder per retired bit. Sums wrap mod 2^(2*XLEN),
    // which is exactly the wrap the product needs.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_bits[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
//
// Purpose: iterative shift-add multiply unit for the RV32M multiply group
// (mul, mulh, mulhsu, mulhu). Signed ops are handled by multiplying unsigned
// magnitudes and negating the 2*XLEN product at the end when exactly one
// signed operand was negative. One-cycle mul_done pulse; result is held until
// the next completion.
//
// Ports:
//   clk       in   1     rising-edge clock
//   rst       in   1     synchronous active-high reset
//   start     in   1     request, sampled only while ready=1
//   mulctl    in   2     op select: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu
//   rs1       in   XLEN  multiplicand
//   rs2       in   XLEN  multiplier
//   flush     in   1     kills any in-flight operation
//   ready     out  1     start will be accepted (IDLE or DONE)
//   mul_done  out  1     one-cycle pulse, result valid
//   result    out  XLEN  low half for mul, high half otherwise
// -----------------------------------------------------------------------------
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mulctl,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            ready,
    output logic            mul_done,
    output logic [XLEN-1:0] result
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    // Reject configurations the datapath was not built for.
    if (XLEN != 32) begin : g_bad_xlen
        $error("mul_unit: only XLEN=32 is supported");
    end
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
        $error("mul_unit: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    mul_state_e             state_q;
    mul_state_e             state_d;

    logic [1:0]             op_q;
    logic                   neg_q;
    logic [2*XLEN-1:0]      mcand_q;
    logic [XLEN-1:0]        mplier_q;
    logic [2*XLEN-1:0]      acc_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [XLEN-1:0]        result_q;

    logic                   accept;
    logic                   last_step;
    logic                   rs1_neg;
    logic                   rs2_neg;
    logic [XLEN-1:0]        rs1_mag;
    logic [XLEN-1:0]        rs2_mag;
    logic [2*XLEN-1:0]      acc_next;
    logic [2*XLEN-1:0]      product;

    // Operand pre-processing: an operand is negated to its magnitude only if it
    // is signed for this op and its MSB is set. -2^31 maps to 2^31 unsigned,
    // which the unsigned datapath handles without special casing.
    always_comb begin
        rs1_neg = rs1_is_signed(mulctl) & rs1[XLEN-1];
        rs2_neg = rs2_is_signed(mulctl) & rs2[XLEN-1];
        rs1_mag = rs1_neg ? -rs1 : rs1;
        rs2_mag = rs2_neg ? -rs2 : rs2;
    end

    // Handshake and completion qualifiers shared by the FSM and the datapath.
    always_comb begin
        accept    = ready && start && !flush;
        last_step = (state_q == ST_RUN) && (cnt_q == CNT_W'(STEPS - 1));
    end

    mul_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_mul_step (
        .acc         (acc_q),
        .mcand       (mcand_q),
        .mplier_bits (mplier_q[BITS_PER_CYCLE-1:0]),
        .acc_next    (acc_next)
    );

    // Post-processing: the final step's sum is negated as a full 2*XLEN value
    // so the high half comes out right for the signed ops.
    always_comb begin
        product = neg_q ? -acc_next : acc_next;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. flush beats both a new start and the
    // completing step on the same edge.
    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        mul_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ready    = 1'b1;
                mul_done = 1'b1;
                state_d  = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Datapath: capture magnitudes on accept, then retire BITS_PER_CYCLE
    // multiplier bits per RUN edge by shifting the multiplicand up and the
    // multiplier down. The result register only moves on a completing edge,
    // so it holds across DONE, IDLE, back-to-back starts and flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= mulctl;
            neg_q    <= rs1_neg ^ rs2_neg;
            mcand_q  <= {{XLEN{1'b0}}, rs1_mag};
            mplier_q <= rs2_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if ((state_q == ST_RUN) && !flush) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_step) begin
                result_q <= (op_q == MULCTL_MUL) ? product[XLEN-1:0]
                                                 : product[2*XLEN-1:XLEN];
            end
        end
    end

    assign result = result_q;

endmodule
